// File: rtl/decode_pipe.sv
// decode_pipe: 8-entry register file, instruction field split, load-use hazard detection and ID/EX register.
// Build option: define DECODE_BYPASS_EN to forward same-cycle writeback data to register reads.
module decode_pipe #(
  parameter int DATA_W   = 16,
  parameter int JOFF_W   = 11,
  parameter int LINK_REG = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  output logic              id_ready,
  output logic [4:0]        id_opcode,
  input  logic [1:0]        ctl_regdst,
  input  logic              ctl_regwrite,
  input  logic              ctl_memread,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_reg1,
  output logic [DATA_W-1:0] ex_reg2,
  output logic [DATA_W-1:0] ex_joff,
  output logic [7:0]        ex_imm,
  output logic [4:0]        ex_opcode,
  output logic [2:0]        ex_wsel,
  output logic              ex_regwrite,
  output logic              ex_memread
);

  localparam logic [2:0] LINK_SEL = 3'(LINK_REG);

  function automatic logic signed [DATA_W-1:0] sext_joff(input logic [JOFF_W-1:0] f);
    return {{(DATA_W-JOFF_W){f[JOFF_W-1]}}, f};
  endfunction

  logic [DATA_W-1:0] rf [8];

  logic [2:0]               rsel1_p0, rsel2_p0, wsel_p0;
  logic [DATA_W-1:0]        rd1_p0, rd2_p0;
  logic signed [DATA_W-1:0] joff_p0;
  logic                     hz_p0;

  logic                     vld_p1;
  logic [DATA_W-1:0]        reg1_p1, reg2_p1;
  logic signed [DATA_W-1:0] joff_p1;
  logic [7:0]               imm_p1;
  logic [4:0]               opcode_p1;
  logic [2:0]               wsel_p1;
  logic                     regwrite_p1, memread_p1;

  // Register file: writeback always lands, independent of stall, flush or hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_sel] <= wb_data;
    end
  end

  // ---- p0: combinational decode of the fetched instruction ----
  assign rsel1_p0  = if_instr[10:8];
  assign rsel2_p0  = if_instr[7:5];
  assign id_opcode = if_instr[15:11];
  assign joff_p0   = sext_joff(if_instr[JOFF_W-1:0]);

  always_comb begin
    rd1_p0 = rf[rsel1_p0];
    rd2_p0 = rf[rsel2_p0];
`ifdef DECODE_BYPASS_EN
    if (wb_en && (wb_sel == rsel1_p0)) rd1_p0 = wb_data;
    if (wb_en && (wb_sel == rsel2_p0)) rd2_p0 = wb_data;
`endif
  end

  always_comb begin
    case (ctl_regdst)
      2'd0:    wsel_p0 = if_instr[10:8];
      2'd1:    wsel_p0 = if_instr[7:5];
      2'd2:    wsel_p0 = if_instr[4:2];
      default: wsel_p0 = LINK_SEL;
    endcase
  end

  // A load still in ID/EX cannot forward its result to a consumer in decode.
  assign hz_p0 = if_valid & vld_p1 & memread_p1 & regwrite_p1 &
                 ((wsel_p1 == rsel1_p0) | (wsel_p1 == rsel2_p0));

  assign id_ready = flush | ~(ex_stall | hz_p0);

  // ---- p1: ID/EX pipeline register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      reg1_p1     <= '0;
      reg2_p1     <= '0;
      joff_p1     <= '0;
      imm_p1      <= '0;
      opcode_p1   <= '0;
      wsel_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      reg1_p1     <= '0;
      reg2_p1     <= '0;
      joff_p1     <= '0;
      imm_p1      <= '0;
      opcode_p1   <= '0;
      wsel_p1     <= '0;
    end else if (ex_stall) begin
      vld_p1      <= vld_p1;
    end else if (hz_p0) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
    end else begin
      vld_p1      <= if_valid;
      regwrite_p1 <= ctl_regwrite & if_valid;
      memread_p1  <= ctl_memread & if_valid;
      reg1_p1     <= rd1_p0;
      reg2_p1     <= rd2_p0;
      joff_p1     <= joff_p0;
      imm_p1      <= if_instr[7:0];
      opcode_p1   <= if_instr[15:11];
      wsel_p1     <= wsel_p0;
    end
  end

  assign ex_valid    = vld_p1;
  assign ex_reg1     = reg1_p1;
  assign ex_reg2     = reg2_p1;
  assign ex_joff     = joff_p1;
  assign ex_imm      = imm_p1;
  assign ex_opcode   = opcode_p1;
  assign ex_wsel     = wsel_p1;
  assign ex_regwrite = regwrite_p1;
  assign ex_memread  = memread_p1;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: table vectors, directed corner sequences and randomized traffic against a behavioural model.
module tb_decode_pipe;
  localparam int DW = 16;
`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_valid, ctl_regwrite, ctl_memread, ex_stall, flush, wb_en;
  logic [15:0]   if_instr;
  logic [1:0]    ctl_regdst;
  logic [2:0]    wb_sel;
  logic [DW-1:0] wb_data;
  logic          id_ready, ex_valid, ex_regwrite, ex_memread;
  logic [4:0]    id_opcode, ex_opcode;
  logic [DW-1:0] ex_reg1, ex_reg2, ex_joff;
  logic [7:0]    ex_imm;
  logic [2:0]    ex_wsel;

  decode_pipe dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .id_ready(id_ready), .id_opcode(id_opcode), .ctl_regdst(ctl_regdst),
    .ctl_regwrite(ctl_regwrite), .ctl_memread(ctl_memread), .ex_stall(ex_stall),
    .flush(flush), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_joff(ex_joff),
    .ex_imm(ex_imm), .ex_opcode(ex_opcode), .ex_wsel(ex_wsel),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] instr;
    logic [1:0]  regdst;
    logic [15:0] joff;
    logic [2:0]  wsel;
    logic [7:0]  imm;
    logic [4:0]  op;
  } vec_t;

  vec_t tbl [5];

  // behavioural model state
  logic [DW-1:0] m_rf [8];
  logic          m_valid, m_rw, m_mr;
  logic [2:0]    m_wsel;
  logic [4:0]    m_op;
  logic [7:0]    m_imm;
  logic [DW-1:0] m_joff, m_r1, m_r2;
  logic [2:0]    ra, rb;
  logic          hz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    if_valid = 0; if_instr = '0; ctl_regdst = '0; ctl_regwrite = 0; ctl_memread = 0;
    ex_stall = 0; flush = 0; wb_en = 0; wb_sel = '0; wb_data = '0;
  endtask

  task automatic issue(input logic [15:0] ins, input logic [1:0] rd, input logic rw, input logic mr);
    if_valid = 1; if_instr = ins; ctl_regdst = rd; ctl_regwrite = rw; ctl_memread = mr;
  endtask

  function automatic logic [2:0] dest(input logic [15:0] ins, input logic [1:0] rd);
    case (rd)
      2'd0:    return ins[10:8];
      2'd1:    return ins[7:5];
      2'd2:    return ins[4:2];
      default: return 3'd7;
    endcase
  endfunction

  initial begin
    tbl[0] = '{16'h0400, 2'd3, 16'hFC00, 3'd7, 8'h00, 5'd0};
    tbl[1] = '{16'h03FF, 2'd0, 16'h03FF, 3'd3, 8'hFF, 5'd0};
    tbl[2] = '{16'hF8A5, 2'd1, 16'h00A5, 3'd5, 8'hA5, 5'd31};
    tbl[3] = '{16'h7FFF, 2'd2, 16'hFFFF, 3'd7, 8'hFF, 5'd15};
    tbl[4] = '{16'h5555, 2'd1, 16'hFD55, 3'd2, 8'h55, 5'd10};

    idle;
    #2 rst = 1;
    tick;
    tick;
    rst = 0;
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_regwrite", ex_regwrite, 0);
    chk("rst_memread", ex_memread, 0);
    chk("rst_fields", {ex_reg1, ex_reg2}, 0);
    chk("rst_fields2", {ex_joff, ex_imm, ex_opcode, ex_wsel}, 0);
    chk("rst_ready", id_ready, 1);

    for (int i = 0; i < 8; i++) begin
      issue({5'd1, 3'(i), 3'(7 - i), 5'd0}, 2'd0, 1'b0, 1'b0);
      tick;
      chk("rst_rf_r1", ex_reg1, 0);
      chk("rst_rf_r2", ex_reg2, 0);
    end

    for (int i = 0; i < 5; i++) begin
      issue(tbl[i].instr, tbl[i].regdst, 1'b1, 1'b0);
      #1;
      chk("tbl_ready", id_ready, 1);
      chk("tbl_id_opcode", id_opcode, tbl[i].op);
      tick;
      chk("tbl_valid", ex_valid, 1);
      chk("tbl_joff", ex_joff, tbl[i].joff);
      chk("tbl_wsel", ex_wsel, tbl[i].wsel);
      chk("tbl_imm", ex_imm, tbl[i].imm);
      chk("tbl_opcode", ex_opcode, tbl[i].op);
      chk("tbl_regwrite", ex_regwrite, 1);
    end

    // write r3 while reading it in the same cycle
    issue({5'd2, 3'd3, 3'd3, 5'd0}, 2'd0, 1'b1, 1'b0);
    wb_en = 1; wb_sel = 3'd3; wb_data = 16'h1234;
    tick;
    wb_en = 0;
    chk("byp_reg1", ex_reg1, BYP ? 16'h1234 : 16'h0000);
    chk("byp_reg2", ex_reg2, BYP ? 16'h1234 : 16'h0000);
    tick;
    chk("wb_late_reg1", ex_reg1, 16'h1234);
    chk("wb_late_reg2", ex_reg2, 16'h1234);

    // load to r2 followed by a consumer of r2
    issue({5'd4, 3'd0, 3'd2, 5'd0}, 2'd1, 1'b1, 1'b1);
    tick;
    chk("ld_memread", ex_memread, 1);
    chk("ld_wsel", ex_wsel, 2);
    issue({5'd5, 3'd2, 3'd1, 5'd0}, 2'd0, 1'b1, 1'b0);
    #1;
    chk("hz_ready", id_ready, 0);
    tick;
    chk("hz_bubble_valid", ex_valid, 0);
    chk("hz_bubble_rw", ex_regwrite, 0);
    chk("hz_bubble_mr", ex_memread, 0);
    chk("hz_ready_after", id_ready, 1);
    tick;
    chk("hz_dep_valid", ex_valid, 1);
    chk("hz_dep_opcode", ex_opcode, 5);

    // three-cycle stall with writeback of r5 during it
    issue({5'd6, 3'd1, 3'd1, 5'd0}, 2'd0, 1'b1, 1'b0);
    tick;
    chk("st_pre_opcode", ex_opcode, 6);
    ex_stall = 1;
    for (int k = 0; k < 3; k++) begin
      issue({5'(7 + k), 3'd4, 3'd4, 5'h1F}, 2'd2, 1'b1, 1'b0);
      wb_en = (k == 0); wb_sel = 3'd5; wb_data = 16'hBEEF;
      #1;
      chk("st_ready", id_ready, 0);
      tick;
      chk("st_opcode", ex_opcode, 6);
      chk("st_imm", ex_imm, 8'h20);
      chk("st_valid", ex_valid, 1);
    end
    wb_en = 0; ex_stall = 0;
    issue({5'd8, 3'd5, 3'd5, 5'd0}, 2'd0, 1'b0, 1'b0);
    tick;
    chk("st_wb_reg1", ex_reg1, 16'hBEEF);
    chk("st_wb_reg2", ex_reg2, 16'hBEEF);
    chk("st_rel_opcode", ex_opcode, 8);

    // flush together with stall
    flush = 1; ex_stall = 1;
    issue({5'd3, 3'd5, 3'd5, 5'd0}, 2'd0, 1'b1, 1'b0);
    #1;
    chk("fl_ready", id_ready, 1);
    tick;
    chk("fl_valid", ex_valid, 0);
    chk("fl_opcode", ex_opcode, 0);
    chk("fl_reg1", ex_reg1, 0);
    chk("fl_regwrite", ex_regwrite, 0);
    flush = 0; ex_stall = 0;

    // reset arriving mid-stall
    issue({5'd9, 3'd0, 3'd0, 5'd0}, 2'd0, 1'b1, 1'b0);
    tick;
    chk("rs_pre_valid", ex_valid, 1);
    ex_stall = 1;
    tick;
    chk("rs_hold_valid", ex_valid, 1);
    #2 rst = 1;
    #1;
    chk("rs_async_valid", ex_valid, 0);
    chk("rs_async_opcode", ex_opcode, 0);
    tick;
    rst = 0;
    tick;
    chk("rs_release_valid", ex_valid, 0);
    ex_stall = 0;
    issue({5'd10, 3'd5, 3'd5, 5'd0}, 2'd0, 1'b0, 1'b0);
    tick;
    chk("rs_rf_cleared", ex_reg1, 0);
    chk("rs_load_valid", ex_valid, 1);

    // randomized traffic against the model, from a fresh reset
    idle;
    rst = 1;
    tick;
    rst = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_valid = 0; m_rw = 0; m_mr = 0; m_wsel = '0; m_op = '0; m_imm = '0; m_joff = '0; m_r1 = '0; m_r2 = '0;
    for (int n = 0; n < 600; n++) begin
      if_valid     = ($urandom_range(3) != 0);
      if_instr     = 16'($urandom);
      ctl_regdst   = 2'($urandom);
      ctl_regwrite = ($urandom_range(3) != 0);
      ctl_memread  = ($urandom_range(2) == 0);
      ex_stall     = ($urandom_range(4) == 0);
      flush        = ($urandom_range(9) == 0);
      wb_en        = 1'($urandom_range(1));
      wb_sel       = 3'($urandom);
      wb_data      = 16'($urandom);
      #1;
      ra = if_instr[10:8];
      rb = if_instr[7:5];
      hz = if_valid && m_valid && m_mr && m_rw && (m_wsel == ra || m_wsel == rb);
      chk("rnd_ready", id_ready, flush || !(ex_stall || hz));
      chk("rnd_id_opcode", id_opcode, if_instr[15:11]);
      if (flush) begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_wsel = '0; m_op = '0; m_imm = '0;
        m_joff = '0; m_r1 = '0; m_r2 = '0;
      end else if (ex_stall) begin
        m_valid = m_valid;
      end else if (hz) begin
        m_valid = 0; m_rw = 0; m_mr = 0;
      end else begin
        m_valid = if_valid;
        m_rw    = if_valid && ctl_regwrite;
        m_mr    = if_valid && ctl_memread;
        m_wsel  = dest(if_instr, ctl_regdst);
        m_op    = if_instr[15:11];
        m_imm   = if_instr[7:0];
        m_joff  = 16'($signed(if_instr[10:0]));
        m_r1    = (BYP && wb_en && wb_sel == ra) ? wb_data : m_rf[ra];
        m_r2    = (BYP && wb_en && wb_sel == rb) ? wb_data : m_rf[rb];
      end
      if (wb_en) m_rf[wb_sel] = wb_data;
      tick;
      chk("rnd_valid", ex_valid, m_valid);
      chk("rnd_regwrite", ex_regwrite, m_rw);
      chk("rnd_memread", ex_memread, m_mr);
      if (m_valid) begin
        chk("rnd_reg1", ex_reg1, m_r1);
        chk("rnd_reg2", ex_reg2, m_r2);
        chk("rnd_joff", ex_joff, m_joff);
        chk("rnd_imm", ex_imm, m_imm);
        chk("rnd_opcode", ex_opcode, m_op);
        chk("rnd_wsel", ex_wsel, m_wsel);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Pipelined, parametrised decode stage for the multi-cycle datapath. Holds the 8-entry register file with write-before-read bypass, splits the fetched instruction into operand, immediate and offset fields, and registers everything into an ID/EX pipeline register. Detects load-use hazards and honours downstream stall and branch flush. Sits between fetch and execute; the control block decodes `id_opcode` combinationally and returns its decisions in the same cycle.

## Interface
Parameters:
- `DATA_W`, 16: register and datapath width.
- `JOFF_W`, 11: width of the jump offset field `instr[JOFF_W-1:0]`, sign-extended to `DATA_W`.
- `LINK_REG`, 7: destination register selected when `ctl_regdst`=3.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_valid`  in  1  `if_instr` holds a valid instruction.
- `if_instr`  in  16  instruction from fetch.
- `id_ready`  out  1  decode accepts `if_instr` this cycle. Fetch holds PC/instr when 0.
- `id_opcode`  out  5  `if_instr[15:11]`, combinational, to control.
- `ctl_regdst`  in  2  dest select: 0=`[10:8]`, 1=`[7:5]`, 2=`[4:2]`, 3=`LINK_REG`.
- `ctl_regwrite`  in  1  instruction writes a register.
- `ctl_memread`  in  1  instruction is a load.
- `ex_stall`  in  1  execute cannot accept; hold the ID/EX register.
- `flush`  in  1  taken branch/jump; kill the instruction in decode.
- `wb_en`  in  1  writeback enable.
- `wb_sel`  in  3  writeback register.
- `wb_data`  in  `DATA_W`  writeback data.
- `ex_valid`  out  1  ID/EX register holds a live instruction.
- `ex_reg1`, `ex_reg2`  out  `DATA_W` each  registered reads of `[10:8]` and `[7:5]`.
- `ex_joff`  out  `DATA_W`  registered sign-extended jump offset.
- `ex_imm`  out  8  registered `instr[7:0]`.
- `ex_opcode`  out  5  registered opcode.
- `ex_wsel`  out  3  registered destination register.
- `ex_regwrite`, `ex_memread`  out  1 each  registered control bits. Both are forced to 0 when the entry is a bubble.

## Operation
- Register file: 8 × `DATA_W` flops. Written on the clock edge when `wb_en`=1. Writeback is never blocked by stall, flush or hazard.
- Reads are combinational on `if_instr[10:8]` and `[7:5]`, with bypass per Configuration.
- Load-use hazard: `hz` = `if_valid` & `ex_valid` & `ex_memread` & `ex_regwrite` & (`ex_wsel`==`if_instr[10:8]` | `ex_wsel`==`if_instr[7:5]`).
- Next-state priority: rst > flush > ex_stall > hz > load.
  - flush: `ex_valid`←0, other ex_* ←0. `id_ready`=1, so the wrong-path instruction is dropped.
  - ex_stall (no flush): all ex_* hold. `id_ready`=0.
  - hz (no flush/stall): bubble (`ex_valid`←0, control bits ←0). `id_ready`=0, so the dependent instruction is re-presented the next cycle.
  - load: `ex_valid`←`if_valid`, fields captured. `id_ready`=1.
- An invalid instruction (`if_valid`=0) loads as a bubble. `id_ready`=1.
- Sign extension: `ex_joff` = {(`DATA_W`-`JOFF_W`){instr[`JOFF_W`-1]}, instr[`JOFF_W`-1:0]}.

## Timing
- Reset (async, immediate): all 8 registers =0; all ex_* =0.
- `id_ready` and `id_opcode` are combinational.
- Decode latency: 1 cycle from acceptance to ex_* valid.
- A load followed by a dependent instruction costs exactly 1 bubble.
- Writeback becomes visible in the register array on the next cycle, or the same cycle when bypassed.
- Simultaneous flush and ex_stall: flush wins.
- Simultaneous hz and ex_stall: stall, no bubble inserted.
- Reset asserted mid-stall: the stall state is discarded and ex_valid=0 on release.

## Configuration
- `DECODE_BYPASS_EN` defined: a read whose select equals `wb_sel` while `wb_en`=1 returns `wb_data` in the same cycle.
- Not defined: such a read returns the pre-write array value. Writeback must then be separated from dependent reads by the hazard logic outside this block.

## Test plan
- Reset then idle: every ex_* =0, `id_ready`=1, and reads of r0–r7 return 0.
- Write r3=0x1234, then issue `[10:8]`=3 with `[7:5]`=3 in the same cycle. With bypass: `ex_reg1`=`ex_reg2`=0x1234 next cycle. Without bypass: both =0.
- Load to r2 (`ctl_memread`=1, `ctl_regdst`=1, `[7:5]`=2), then an instruction reading r2: one cycle with `id_ready`=0 and `ex_valid`=0, then the dependent instruction loads with `ex_valid`=1.
- Hold `ex_stall`=1 for 3 cycles with valid instructions arriving: ex_* frozen, `id_ready`=0 throughout, and the write of r5=0xBEEF during the stall still lands.
- Assert `flush` together with `ex_stall`: next cycle `ex_valid`=0 and `id_ready`=1.
- `if_instr[10:0]`=0x400 → `ex_joff`=0xFC00. `[10:0]`=0x3FF → 0x03FF. `ctl_regdst`=3 → `ex_wsel`=7.
